// File: rtl/axi_mem_arbiter_pkg.sv
// rtl/axi_mem_arbiter_pkg.sv - shared types and encodings for the 2:1 AXI memory arbiter
//
// Purpose: arbiter FSM state enum, AXI burst/resp encodings and the ID width.
// Ports:   none (package).
package axi_mem_arbiter_pkg;

  localparam int ID_W = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  // RD1/WR1 grant master 1, RD0/WR0 grant master 0.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    RD1  = 3'd2,
    WR0  = 3'd3,
    WR1  = 3'd4
  } arb_state_t;

endpackage

// File: rtl/axi_arb_chan_mux.sv
// rtl/axi_arb_chan_mux.sv - 2:1 master-to-slave payload mux with valid/ready gating
//
// Purpose: forwards one request channel (AR, AW or W) of the granted master to the slave.
// Ports:
//   act             - channel belongs to the current grant; payload is zero otherwise
//   sel             - granted master (0/1)
//   done            - channel already completed its handshake(s); masks valid and ready
//   m0_*/m1_*       - master payload, valid in, ready out
//   s_data/s_valid  - slave payload and valid out; s_ready in
module axi_arb_chan_mux #(
  parameter int W = 8
) (
  input  logic         act,
  input  logic         sel,
  input  logic         done,
  input  logic [W-1:0] m0_data,
  input  logic         m0_valid,
  output logic         m0_ready,
  input  logic [W-1:0] m1_data,
  input  logic         m1_valid,
  output logic         m1_ready,
  output logic [W-1:0] s_data,
  output logic         s_valid,
  input  logic         s_ready
);

  logic open;

  assign open     = act & ~done;
  assign s_data   = act ? (sel ? m1_data : m0_data) : '0;
  assign s_valid  = open & (sel ? m1_valid : m0_valid);
  assign m0_ready = open & ~sel & s_ready;
  assign m1_ready = open & sel & s_ready;

endmodule

// File: rtl/axi_mem_arbiter.sv
// rtl/axi_mem_arbiter.sv - 2-master (IFU=m0, LSU=m1) to 1-slave AXI4 transaction arbiter
//
// Purpose: grants one whole transaction (AR+R beats, or AW+W beats+B) at a time and muxes
//          the granted master's channels straight through to the memory slave.
// Option:  AXI_ARB_ROUND_ROBIN_EN - when defined, simultaneous requests go to the master
//          other than the one that completed last; otherwise master 1 has fixed priority.
// Ports:
//   clock, reset          - rising-edge clock, asynchronous active-high reset
//   m{0,1}_aw*/w*/b*      - master write address, write data, write response
//   m{0,1}_ar*/r*         - master read address, read data
//   s_aw*/w*/b*/ar*/r*    - memory slave side of the same channels
module axi_mem_arbiter
  import axi_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_awaddr,
  input  logic                m0_awvalid,
  input  logic [ID_W-1:0]     m0_awid,
  input  logic [7:0]          m0_awlen,
  input  logic [2:0]          m0_awsize,
  input  logic [1:0]          m0_awburst,
  output logic                m0_awready,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  input  logic                m0_wvalid,
  input  logic                m0_wlast,
  output logic                m0_wready,
  output logic [1:0]          m0_bresp,
  output logic                m0_bvalid,
  output logic [ID_W-1:0]     m0_bid,
  input  logic                m0_bready,
  input  logic [ADDR_W-1:0]   m0_araddr,
  input  logic                m0_arvalid,
  input  logic [ID_W-1:0]     m0_arid,
  input  logic [7:0]          m0_arlen,
  input  logic [2:0]          m0_arsize,
  input  logic [1:0]          m0_arburst,
  output logic                m0_arready,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic [1:0]          m0_rresp,
  output logic                m0_rvalid,
  output logic                m0_rlast,
  output logic [ID_W-1:0]     m0_rid,
  input  logic                m0_rready,
  input  logic [ADDR_W-1:0]   m1_awaddr,
  input  logic                m1_awvalid,
  input  logic [ID_W-1:0]     m1_awid,
  input  logic [7:0]          m1_awlen,
  input  logic [2:0]          m1_awsize,
  input  logic [1:0]          m1_awburst,
  output logic                m1_awready,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic                m1_wvalid,
  input  logic                m1_wlast,
  output logic                m1_wready,
  output logic [1:0]          m1_bresp,
  output logic                m1_bvalid,
  output logic [ID_W-1:0]     m1_bid,
  input  logic                m1_bready,
  input  logic [ADDR_W-1:0]   m1_araddr,
  input  logic                m1_arvalid,
  input  logic [ID_W-1:0]     m1_arid,
  input  logic [7:0]          m1_arlen,
  input  logic [2:0]          m1_arsize,
  input  logic [1:0]          m1_arburst,
  output logic                m1_arready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic [1:0]          m1_rresp,
  output logic                m1_rvalid,
  output logic                m1_rlast,
  output logic [ID_W-1:0]     m1_rid,
  input  logic                m1_rready,
  output logic [ADDR_W-1:0]   s_awaddr,
  output logic                s_awvalid,
  output logic [ID_W-1:0]     s_awid,
  output logic [7:0]          s_awlen,
  output logic [2:0]          s_awsize,
  output logic [1:0]          s_awburst,
  input  logic                s_awready,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_wvalid,
  output logic                s_wlast,
  input  logic                s_wready,
  input  logic [1:0]          s_bresp,
  input  logic                s_bvalid,
  input  logic [ID_W-1:0]     s_bid,
  output logic                s_bready,
  output logic [ADDR_W-1:0]   s_araddr,
  output logic                s_arvalid,
  output logic [ID_W-1:0]     s_arid,
  output logic [7:0]          s_arlen,
  output logic [2:0]          s_arsize,
  output logic [1:0]          s_arburst,
  input  logic                s_arready,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic [1:0]          s_rresp,
  input  logic                s_rvalid,
  input  logic                s_rlast,
  input  logic [ID_W-1:0]     s_rid,
  output logic                s_rready
);

  localparam int A_W  = ADDR_W + ID_W + 8 + 3 + 2;
  localparam int WD_W = DATA_W + DATA_W/8 + 1;

  arb_state_t state;
  logic ar_done, aw_done, w_done;
  logic rd_act, wr_act, sel;
  logic req0, req1, pick, pick_wr;
  logic rd_end, wr_end;

  assign rd_act = (state == RD0) || (state == RD1);
  assign wr_act = (state == WR0) || (state == WR1);
  assign sel    = (state == RD1) || (state == WR1);

  assign req0 = m0_arvalid | m0_awvalid;
  assign req1 = m1_arvalid | m1_awvalid;

`ifdef AXI_ARB_ROUND_ROBIN_EN
  logic last_grant;

  assign pick = (req0 & req1) ? ~last_grant : req1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                 last_grant <= 1'b0;
    else if (rd_end | wr_end)  last_grant <= sel;
  end
`else
  assign pick = req1;
`endif

  // A master asking for both a write and a read gets the write first.
  assign pick_wr = pick ? m1_awvalid : m0_awvalid;

  assign rd_end = rd_act & s_rvalid & s_rready & s_rlast;
  assign wr_end = wr_act & s_bvalid & s_bready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ar_done <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 | req1)
            state <= pick_wr ? (pick ? WR1 : WR0) : (pick ? RD1 : RD0);
        end
        RD0, RD1: begin
          if (s_arvalid & s_arready) ar_done <= 1'b1;
          if (rd_end) begin
            state   <= IDLE;
            ar_done <= 1'b0;
          end
        end
        WR0, WR1: begin
          if (s_awvalid & s_awready)          aw_done <= 1'b1;
          if (s_wvalid & s_wready & s_wlast)  w_done  <= 1'b1;
          if (wr_end) begin
            state   <= IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [A_W-1:0]  s_ar_pl, s_aw_pl;
  logic [WD_W-1:0] s_w_pl;

  axi_arb_chan_mux #(.W(A_W)) u_ar_mux (
    .act      (rd_act),
    .sel      (sel),
    .done     (ar_done),
    .m0_data  ({m0_araddr, m0_arid, m0_arlen, m0_arsize, m0_arburst}),
    .m0_valid (m0_arvalid),
    .m0_ready (m0_arready),
    .m1_data  ({m1_araddr, m1_arid, m1_arlen, m1_arsize, m1_arburst}),
    .m1_valid (m1_arvalid),
    .m1_ready (m1_arready),
    .s_data   (s_ar_pl),
    .s_valid  (s_arvalid),
    .s_ready  (s_arready)
  );

  axi_arb_chan_mux #(.W(A_W)) u_aw_mux (
    .act      (wr_act),
    .sel      (sel),
    .done     (aw_done),
    .m0_data  ({m0_awaddr, m0_awid, m0_awlen, m0_awsize, m0_awburst}),
    .m0_valid (m0_awvalid),
    .m0_ready (m0_awready),
    .m1_data  ({m1_awaddr, m1_awid, m1_awlen, m1_awsize, m1_awburst}),
    .m1_valid (m1_awvalid),
    .m1_ready (m1_awready),
    .s_data   (s_aw_pl),
    .s_valid  (s_awvalid),
    .s_ready  (s_awready)
  );

  axi_arb_chan_mux #(.W(WD_W)) u_w_mux (
    .act      (wr_act),
    .sel      (sel),
    .done     (w_done),
    .m0_data  ({m0_wdata, m0_wstrb, m0_wlast}),
    .m0_valid (m0_wvalid),
    .m0_ready (m0_wready),
    .m1_data  ({m1_wdata, m1_wstrb, m1_wlast}),
    .m1_valid (m1_wvalid),
    .m1_ready (m1_wready),
    .s_data   (s_w_pl),
    .s_valid  (s_wvalid),
    .s_ready  (s_wready)
  );

  assign {s_araddr, s_arid, s_arlen, s_arsize, s_arburst} = s_ar_pl;
  assign {s_awaddr, s_awid, s_awlen, s_awsize, s_awburst} = s_aw_pl;
  assign {s_wdata, s_wstrb, s_wlast}                      = s_w_pl;

  // Response channels: slave R/B routed to the granted master only.
  always_comb begin
    m0_rdata = '0; m0_rresp = '0; m0_rvalid = 1'b0; m0_rlast = 1'b0; m0_rid = '0;
    m1_rdata = '0; m1_rresp = '0; m1_rvalid = 1'b0; m1_rlast = 1'b0; m1_rid = '0;
    s_rready = 1'b0;
    if (rd_act) begin
      if (sel) begin
        m1_rdata = s_rdata; m1_rresp = s_rresp; m1_rvalid = s_rvalid;
        m1_rlast = s_rlast; m1_rid = s_rid; s_rready = m1_rready;
      end else begin
        m0_rdata = s_rdata; m0_rresp = s_rresp; m0_rvalid = s_rvalid;
        m0_rlast = s_rlast; m0_rid = s_rid; s_rready = m0_rready;
      end
    end
  end

  always_comb begin
    m0_bresp = '0; m0_bvalid = 1'b0; m0_bid = '0;
    m1_bresp = '0; m1_bvalid = 1'b0; m1_bid = '0;
    s_bready = 1'b0;
    if (wr_act) begin
      if (sel) begin
        m1_bresp = s_bresp; m1_bvalid = s_bvalid; m1_bid = s_bid; s_bready = m1_bready;
      end else begin
        m0_bresp = s_bresp; m0_bvalid = s_bvalid; m0_bid = s_bid; s_bready = m0_bready;
      end
    end
  end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// tb/tb_axi_mem_arbiter.sv - directed self-checking bench for axi_mem_arbiter with a memory slave model
module tb_axi_mem_arbiter;
  import axi_mem_arbiter_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [1:0]  m_awvalid, m_awready, m_wvalid, m_wlast, m_wready, m_bvalid, m_bready;
  logic [1:0]  m_arvalid, m_arready, m_rvalid, m_rlast, m_rready;
  logic [31:0] m_awaddr [2], m_wdata [2], m_araddr [2], m_rdata [2];
  logic [3:0]  m_awid [2], m_wstrb [2], m_bid [2], m_arid [2], m_rid [2];
  logic [7:0]  m_awlen [2], m_arlen [2];
  logic [2:0]  m_awsize [2], m_arsize [2];
  logic [1:0]  m_awburst [2], m_arburst [2], m_bresp [2], m_rresp [2];

  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [3:0]  s_awid, s_wstrb, s_bid, s_arid, s_rid;
  logic [7:0]  s_awlen, s_arlen;
  logic [2:0]  s_awsize, s_arsize;
  logic [1:0]  s_awburst, s_arburst, s_bresp, s_rresp;
  logic        s_awvalid, s_awready, s_wvalid, s_wlast, s_wready, s_bvalid, s_bready;
  logic        s_arvalid, s_arready, s_rvalid, s_rlast, s_rready;

  axi_mem_arbiter dut (
    .clock(clock), .reset(reset),
    .m0_awaddr(m_awaddr[0]), .m0_awvalid(m_awvalid[0]), .m0_awid(m_awid[0]), .m0_awlen(m_awlen[0]),
    .m0_awsize(m_awsize[0]), .m0_awburst(m_awburst[0]), .m0_awready(m_awready[0]),
    .m0_wdata(m_wdata[0]), .m0_wstrb(m_wstrb[0]), .m0_wvalid(m_wvalid[0]), .m0_wlast(m_wlast[0]),
    .m0_wready(m_wready[0]), .m0_bresp(m_bresp[0]), .m0_bvalid(m_bvalid[0]), .m0_bid(m_bid[0]),
    .m0_bready(m_bready[0]), .m0_araddr(m_araddr[0]), .m0_arvalid(m_arvalid[0]), .m0_arid(m_arid[0]),
    .m0_arlen(m_arlen[0]), .m0_arsize(m_arsize[0]), .m0_arburst(m_arburst[0]), .m0_arready(m_arready[0]),
    .m0_rdata(m_rdata[0]), .m0_rresp(m_rresp[0]), .m0_rvalid(m_rvalid[0]), .m0_rlast(m_rlast[0]),
    .m0_rid(m_rid[0]), .m0_rready(m_rready[0]),
    .m1_awaddr(m_awaddr[1]), .m1_awvalid(m_awvalid[1]), .m1_awid(m_awid[1]), .m1_awlen(m_awlen[1]),
    .m1_awsize(m_awsize[1]), .m1_awburst(m_awburst[1]), .m1_awready(m_awready[1]),
    .m1_wdata(m_wdata[1]), .m1_wstrb(m_wstrb[1]), .m1_wvalid(m_wvalid[1]), .m1_wlast(m_wlast[1]),
    .m1_wready(m_wready[1]), .m1_bresp(m_bresp[1]), .m1_bvalid(m_bvalid[1]), .m1_bid(m_bid[1]),
    .m1_bready(m_bready[1]), .m1_araddr(m_araddr[1]), .m1_arvalid(m_arvalid[1]), .m1_arid(m_arid[1]),
    .m1_arlen(m_arlen[1]), .m1_arsize(m_arsize[1]), .m1_arburst(m_arburst[1]), .m1_arready(m_arready[1]),
    .m1_rdata(m_rdata[1]), .m1_rresp(m_rresp[1]), .m1_rvalid(m_rvalid[1]), .m1_rlast(m_rlast[1]),
    .m1_rid(m_rid[1]), .m1_rready(m_rready[1]),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awid(s_awid), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awready(s_awready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_wvalid(s_wvalid), .s_wlast(s_wlast), .s_wready(s_wready), .s_bresp(s_bresp),
    .s_bvalid(s_bvalid), .s_bid(s_bid), .s_bready(s_bready), .s_araddr(s_araddr),
    .s_arvalid(s_arvalid), .s_arid(s_arid), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arready(s_arready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rvalid(s_rvalid), .s_rlast(s_rlast), .s_rid(s_rid), .s_rready(s_rready)
  );

  // ---------------- memory slave model ----------------
  function automatic logic [31:0] init_val(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  logic [31:0] mem [256];
  logic        rd_busy, aw_got, w_got, b_pend;
  logic [31:0] rd_addr, aw_addr_q, w_data_q;
  logic [7:0]  rd_left;
  logic [3:0]  rd_id_q, aw_id_q, w_strb_q;

  assign s_arready = ~rd_busy;
  assign s_rvalid  = rd_busy;
  assign s_rdata   = mem[rd_addr[9:2]];
  assign s_rlast   = rd_busy & (rd_left == 8'd0);
  assign s_rid     = rd_id_q;
  assign s_rresp   = (rd_addr[31:28] == 4'hF) ? RESP_SLVERR : RESP_OKAY;
  assign s_awready = ~aw_got & ~b_pend;
  assign s_wready  = ~w_got & ~b_pend;
  assign s_bvalid  = b_pend;
  assign s_bid     = aw_id_q;
  assign s_bresp   = (aw_addr_q[31:28] == 4'hF) ? RESP_SLVERR : RESP_OKAY;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_busy <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0;
      rd_addr <= '0; rd_left <= '0; rd_id_q <= '0;
      aw_addr_q <= '0; aw_id_q <= '0; w_data_q <= '0; w_strb_q <= '0;
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else begin
      if (s_arvalid & s_arready) begin
        rd_busy <= 1'b1; rd_addr <= s_araddr; rd_left <= s_arlen; rd_id_q <= s_arid;
      end else if (s_rvalid & s_rready) begin
        rd_addr <= rd_addr + 32'd4;
        if (rd_left == 8'd0) rd_busy <= 1'b0;
        else                 rd_left <= rd_left - 8'd1;
      end
      if (s_awvalid & s_awready) begin
        aw_got <= 1'b1; aw_addr_q <= s_awaddr; aw_id_q <= s_awid;
      end
      if (s_wvalid & s_wready) begin
        w_data_q <= s_wdata; w_strb_q <= s_wstrb;
        if (s_wlast) w_got <= 1'b1;
      end
      if (aw_got & w_got & ~b_pend) begin
        b_pend <= 1'b1;
        for (int b = 0; b < 4; b++)
          if (w_strb_q[b]) mem[aw_addr_q[9:2]][8*b +: 8] <= w_data_q[8*b +: 8];
      end
      if (b_pend & s_bready) begin
        b_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
      end
    end
  end

  // ---------------- monitors ----------------
  int   cyc = 0, sar_hs_cnt = 0, saw_hs_cnt = 0, sw_hs_cnt = 0, m1_nz_cnt = 0, sar_rise_cyc = 0;
  logic sar_prev = 1'b0;
  int   grant_log[$];

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (s_arvalid & s_arready) sar_hs_cnt <= sar_hs_cnt + 1;
    if (s_awvalid & s_awready) saw_hs_cnt <= saw_hs_cnt + 1;
    if (s_wvalid & s_wready)   sw_hs_cnt  <= sw_hs_cnt + 1;
    for (int i = 0; i < 2; i++) begin
      if (m_arvalid[i] & m_arready[i]) grant_log.push_back(i);
      if (m_awvalid[i] & m_awready[i]) grant_log.push_back(2 + i);
    end
  end

  always @(negedge clock) begin
    sar_prev <= s_arvalid;
    if (s_arvalid & ~sar_prev) sar_rise_cyc <= cyc;
    if (m_arready[1] | m_rvalid[1] | m_rlast[1] | m_awready[1] | m_wready[1] | m_bvalid[1] |
        (|m_rdata[1]) | (|m_rresp[1]) | (|m_rid[1]) | (|m_bresp[1]) | (|m_bid[1]))
      m1_nz_cnt <= m1_nz_cnt + 1;
  end

  // ---------------- checking ----------------
  int n_run = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic mread(input int m, input logic [31:0] addr, input logic [7:0] len,
                       input logic [3:0] id, input bit toggle,
                       output int req_cyc, output logic [31:0] data0,
                       output logic [1:0] resp0, output logic [3:0] rid0, output int beats);
    bit fin, ar_hs, r_hs;
    m_araddr[m] = addr; m_arlen[m] = len; m_arid[m] = id;
    m_arsize[m] = 3'd2; m_arburst[m] = BURST_INCR; m_rready[m] = 1'b1; m_arvalid[m] = 1'b1;
    req_cyc = cyc; beats = 0; fin = 0; data0 = '0; resp0 = '0; rid0 = '0;
    for (int k = 0; k < 300 && !fin; k++) begin
      @(negedge clock);
      ar_hs = m_arvalid[m] & m_arready[m];
      r_hs  = m_rvalid[m] & m_rready[m];
      if (r_hs) begin
        if (beats == 0) begin data0 = m_rdata[m]; resp0 = m_rresp[m]; rid0 = m_rid[m]; end
        beats++;
        if (m_rlast[m]) fin = 1;
      end
      @(posedge clock); #1;
      if (ar_hs) m_arvalid[m] = 1'b0;
      m_rready[m] = toggle ? ~m_rready[m] : 1'b1;
    end
    m_rready[m] = 1'b1;
    check($sformatf("rd%0d_complete", m), fin, 1);
  endtask

  task automatic mwrite(input int m, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [3:0] id, input int w_lead,
                        output logic [1:0] bresp, output logic [3:0] bid);
    bit fin, aw_hs, w_hs;
    m_awaddr[m] = addr; m_awid[m] = id; m_awlen[m] = 8'd0; m_awsize[m] = 3'd2;
    m_awburst[m] = BURST_INCR; m_wdata[m] = data; m_wstrb[m] = strb; m_wlast[m] = 1'b1;
    m_bready[m] = 1'b1; m_wvalid[m] = 1'b1;
    if (w_lead == 0) m_awvalid[m] = 1'b1;
    fin = 0; bresp = '0; bid = '0;
    for (int k = 0; k < 300 && !fin; k++) begin
      @(negedge clock);
      aw_hs = m_awvalid[m] & m_awready[m];
      w_hs  = m_wvalid[m] & m_wready[m];
      if (m_bvalid[m] & m_bready[m]) begin bresp = m_bresp[m]; bid = m_bid[m]; fin = 1; end
      @(posedge clock); #1;
      if (aw_hs) m_awvalid[m] = 1'b0;
      if (w_hs)  m_wvalid[m] = 1'b0;
      if (k + 1 == w_lead) m_awvalid[m] = 1'b1;
    end
    check($sformatf("wr%0d_complete", m), fin, 1);
  endtask

  // ---------------- directed tests ----------------
  int          rc0, rc1, nb0, nb1, base, snap_ar, snap_aw, snap_w, snap_nz, exp_first, last_master;
  logic [31:0] d0, d1;
  logic [1:0]  rs0, rs1, br;
  logic [3:0]  id0, id1, bi;
  bit          ar_seen;

  initial begin
    reset = 1'b1;
    m_awvalid = '0; m_wvalid = '0; m_wlast = '0; m_bready = '0; m_arvalid = '0; m_rready = '0;
    for (int i = 0; i < 2; i++) begin
      m_awaddr[i] = '0; m_wdata[i] = '0; m_araddr[i] = '0; m_awid[i] = '0; m_wstrb[i] = '0;
      m_arid[i] = '0; m_awlen[i] = '0; m_arlen[i] = '0; m_awsize[i] = '0; m_arsize[i] = '0;
      m_awburst[i] = '0; m_arburst[i] = '0;
    end
    idle(3);
    check("reset_state", 64'(dut.state), 64'(IDLE));
    check("reset_valid_ready", {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready,
                                m_arready, m_awready, m_wready, m_rvalid, m_bvalid}, 0);
    check("reset_payload", {s_araddr, s_awaddr, s_wdata, s_wlast}, 0);
    reset = 1'b0;
    idle(2);

    // Single read from the IFU.
    snap_nz = m1_nz_cnt;
    mread(0, 32'h8000_0000, 8'd0, 4'h3, 0, rc0, d0, rs0, id0, nb0);
    check("single_sar_latency", sar_rise_cyc, rc0 + 1);
    check("single_rdata", d0, 32'hC0DE_0000);
    check("single_rresp", rs0, RESP_OKAY);
    check("single_rid", id0, 4'h3);
    check("single_beats", nb0, 1);
    check("single_back_idle", 64'(dut.state), 64'(IDLE));
    check("single_m1_quiet", m1_nz_cnt - snap_nz, 0);
    last_master = 0;
    idle(1);

    // Both masters read in the same cycle.
`ifdef AXI_ARB_ROUND_ROBIN_EN
    exp_first = 1 - last_master;
`else
    exp_first = 1;
`endif
    base = grant_log.size();
    fork
      mread(0, 32'h8000_0004, 8'd0, 4'h0, 0, rc0, d0, rs0, id0, nb0);
      mread(1, 32'h8000_0008, 8'd0, 4'h1, 0, rc1, d1, rs1, id1, nb1);
    join
    check("simul_grants", grant_log.size() - base, 2);
    check("simul_first", grant_log[base], exp_first);
    check("simul_second", grant_log[base + 1], 1 - exp_first);
    check("simul_m0_data", d0, init_val(1));
    check("simul_m1_data", d1, init_val(2));
    idle(1);

    // LSU burst read with rready toggling.
    snap_ar = sar_hs_cnt;
    mread(1, 32'h8000_0100, 8'd3, 4'h7, 1, rc1, d1, rs1, id1, nb1);
    check("burst_beats", nb1, 4);
    check("burst_ar_once", sar_hs_cnt - snap_ar, 1);
    check("burst_first_data", d1, init_val(64));
    idle(1);

    // LSU write with W two cycles ahead of AW.
    snap_aw = saw_hs_cnt; snap_w = sw_hs_cnt;
    mwrite(1, 32'h8000_0040, 32'hDEAD_BEEF, 4'hF, 4'h9, 2, br, bi);
    check("wfirst_aw_once", saw_hs_cnt - snap_aw, 1);
    check("wfirst_w_once", sw_hs_cnt - snap_w, 1);
    check("wfirst_bresp", br, RESP_OKAY);
    check("wfirst_bid", bi, 4'h9);
    check("wfirst_mem", mem[16], 32'hDEAD_BEEF);
    check("wfirst_back_idle", 64'(dut.state), 64'(IDLE));
    idle(1);

    // LSU requests write and read together: write goes first, read sees it.
    base = grant_log.size();
    fork
      mwrite(1, 32'h8000_0080, 32'hDEAD_BEEF, 4'hF, 4'h2, 0, br, bi);
      mread(1, 32'h8000_0080, 8'd0, 4'h2, 0, rc1, d1, rs1, id1, nb1);
    join
    check("same_grants", grant_log.size() - base, 2);
    check("same_first_is_wr1", grant_log[base], 3);
    check("same_then_rd1", grant_log[base + 1], 1);
    check("same_readback", d1, 32'hDEAD_BEEF);
    idle(1);

    // Error responses and IDs pass through unchanged.
    mread(0, 32'hF000_0000, 8'd0, 4'hA, 0, rc0, d0, rs0, id0, nb0);
    check("err_rresp", rs0, RESP_SLVERR);
    check("err_rid", id0, 4'hA);
    mwrite(0, 32'hF000_0004, 32'h1234_5678, 4'hF, 4'h6, 0, br, bi);
    check("err_bresp", br, RESP_SLVERR);
    check("err_bid", bi, 4'h6);
    idle(1);

    // Reset during the second beat of a burst.
    m_araddr[0] = 32'h8000_0200; m_arlen[0] = 8'd3; m_arid[0] = 4'h0;
    m_rready[0] = 1'b1; m_arvalid[0] = 1'b1;
    nb0 = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      if (m_rvalid[0]) nb0++;
      if (nb0 == 2) break;
      ar_seen = m_arvalid[0] & m_arready[0];
      @(posedge clock); #1;
      if (ar_seen) m_arvalid[0] = 1'b0;
    end
    check("rst_second_beat_seen", nb0, 2);
    #2 reset = 1'b1;
    #1;
    check("rst_async_idle", 64'(dut.state), 64'(IDLE));
    check("rst_async_valid_ready", {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready,
                                    m_arready, m_awready, m_wready, m_rvalid, m_bvalid}, 0);
    check("rst_async_payload", {s_araddr, m_rdata[0]}, 0);
    m_arvalid[0] = 1'b0;
    idle(2);
    reset = 1'b0;
    idle(1);
    mread(0, 32'h8000_0010, 8'd0, 4'h5, 0, rc0, d0, rs0, id0, nb0);
    check("post_rst_data", d0, init_val(4));
    check("post_rst_beats", nb0, 1);
    check("post_rst_rid", id0, 4'h5);

    idle(2);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
